// File: rtl/ga_main_fsm_mc.sv
// Main control FSM of the GA engine: collects samples, sequences generations, publishes weights.
// Optional stall-based early stop is built only when GA_EARLY_STOP_EN is defined.
module ga_main_fsm_mc #(
    parameter int DATA_W      = 6,
    parameter int M_MAX       = 32,
    parameter int B_MAX       = 64,
    parameter int G_MAX       = 1024,
    parameter int B_MAX_W     = $clog2(B_MAX + 1),
    parameter int G_MAX_W     = $clog2(G_MAX + 1),
    parameter int CHROM_MAX_W = DATA_W * M_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [B_MAX_W-1:0]     cnfg_b,
    input  logic [G_MAX_W-1:0]     cnfg_g,
    input  logic [G_MAX_W-1:0]     cnfg_stall,
    input  logic                   i_ga_enable,
    input  logic                   i_valid_pls,
    input  logic [CHROM_MAX_W-1:0] i_v_vec_flat_n,
    input  logic                   algo_self_gen_created_pls,
    input  logic [CHROM_MAX_W-1:0] algo_self_best_chrom,
    output logic                   o_ga_ready,
    output logic                   o_valid_lvl,
    output logic [CHROM_MAX_W-1:0] o_w_vec_np1,
    output logic [B_MAX_W-1:0]     o_inputs_counter,
    output logic [G_MAX_W-1:0]     o_gen_counter,
    output logic [7:0]             o_drop_cnt,
    output logic                   o_early_stop,
    output logic                   self_algo_init_pop_start,
    output logic                   self_algo_fit_enable,
    output logic                   self_algo_create_new_gen_req_pls,
    output logic                   self_algo_stop_create_new_gens_req_pls,
    output logic                   self_algo_chrom_mux_sel
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_INIT    = 3'd2;
    localparam logic [2:0] S_REQ     = 3'd3;
    localparam logic [2:0] S_WAIT    = 3'd4;
    localparam logic [2:0] S_STOP    = 3'd5;
    localparam logic [2:0] S_READY   = 3'd6;

    localparam logic [B_MAX_W-1:0] B_SAT = B_MAX_W'(B_MAX);

    logic [2:0]             state;
    logic [2:0]             nxt;
    logic                   accept;
    logic                   gen_take;
    logic                   run_done;
    logic                   new_run;
    logic                   stall_hit;
    logic [B_MAX_W-1:0]     b_eff;
    logic [B_MAX_W-1:0]     in_cnt_nxt;
    logic [G_MAX_W-1:0]     g_eff;
    logic [G_MAX_W-1:0]     gen_inc;
    logic [CHROM_MAX_W-1:0] best_q;
    logic [CHROM_MAX_W-1:0] best_nxt;
    logic                   unused_sideband;

    // The sample vector is captured by the datapath; this block only counts strobes.
    assign unused_sideband = ^i_v_vec_flat_n;

    assign b_eff      = (cnfg_b == '0) ? B_MAX_W'(1) : cnfg_b;
    assign g_eff      = (cnfg_g == '0) ? G_MAX_W'(1) : cnfg_g;
    assign accept     = i_valid_pls & o_ga_ready & i_ga_enable;
    assign gen_take   = (state == S_WAIT) & algo_self_gen_created_pls & i_ga_enable;
    assign gen_inc    = o_gen_counter + 1'b1;
    assign in_cnt_nxt = (accept && (o_inputs_counter < B_SAT)) ? o_inputs_counter + 1'b1
                                                                : o_inputs_counter;
    assign best_nxt   = gen_take ? algo_self_best_chrom : best_q;
    assign run_done   = (gen_inc >= g_eff) | stall_hit;
    assign new_run    = (nxt == S_INIT) | ((state == S_READY) & (nxt == S_REQ));

`ifdef GA_EARLY_STOP_EN
    logic [G_MAX_W-1:0] stall_cnt;
    logic [G_MAX_W-1:0] stall_nxt;

    // A generation whose best matches the previous best counts as a stalled generation.
    always_comb begin
        stall_nxt = '0;
        if (algo_self_best_chrom == best_q)
            stall_nxt = (stall_cnt == '1) ? stall_cnt : stall_cnt + 1'b1;
    end

    assign stall_hit = (cnfg_stall != '0) && (stall_nxt >= cnfg_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt    <= '0;
            o_early_stop <= 1'b0;
        end else begin
            if (new_run) begin
                stall_cnt    <= '0;
                o_early_stop <= 1'b0;
            end else if (gen_take) begin
                stall_cnt <= stall_nxt;
                if (nxt == S_STOP)
                    o_early_stop <= stall_hit;
            end
        end
    end
`else
    logic unused_stall_cfg;

    assign unused_stall_cfg = ^cnfg_stall;
    assign stall_hit        = 1'b0;
    assign o_early_stop     = 1'b0;
`endif

    // Dropping the enable overrides every state and returns to IDLE.
    always_comb begin
        nxt = state;
        if (!i_ga_enable) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:    nxt = S_COLLECT;
                S_COLLECT: if (in_cnt_nxt >= b_eff) nxt = S_INIT;
                S_INIT:    nxt = S_REQ;
                S_REQ:     nxt = S_WAIT;
                S_WAIT:    if (gen_take) nxt = run_done ? S_STOP : S_REQ;
                S_STOP:    nxt = S_READY;
                S_READY:   if (accept) nxt = S_REQ;
                default:   nxt = S_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so that they line up with the registered state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state                                  <= S_IDLE;
            o_ga_ready                             <= 1'b0;
            o_valid_lvl                            <= 1'b0;
            o_w_vec_np1                            <= '0;
            o_inputs_counter                       <= '0;
            o_gen_counter                          <= '0;
            o_drop_cnt                             <= '0;
            self_algo_init_pop_start               <= 1'b0;
            self_algo_fit_enable                   <= 1'b0;
            self_algo_create_new_gen_req_pls       <= 1'b0;
            self_algo_stop_create_new_gens_req_pls <= 1'b0;
            self_algo_chrom_mux_sel                <= 1'b0;
            best_q                                 <= '0;
        end else begin
            state                            <= nxt;
            o_ga_ready                       <= (nxt == S_COLLECT) || (nxt == S_READY);
            self_algo_init_pop_start         <= (nxt == S_INIT);
            self_algo_fit_enable             <= (nxt == S_INIT) || (nxt == S_REQ) || (nxt == S_WAIT);
            self_algo_create_new_gen_req_pls <= (nxt == S_REQ);
            self_algo_stop_create_new_gens_req_pls <=
                (nxt == S_STOP) || (!i_ga_enable && ((state == S_REQ) || (state == S_WAIT)));

            if (i_valid_pls && !accept && (o_drop_cnt != 8'hFF))
                o_drop_cnt <= o_drop_cnt + 8'd1;

            if (gen_take)
                best_q <= algo_self_best_chrom;

            if (nxt == S_STOP)
                o_w_vec_np1 <= best_nxt;

            if (!i_ga_enable) begin
                o_inputs_counter <= '0;
                o_gen_counter    <= '0;
                o_valid_lvl      <= 1'b0;
            end else begin
                o_inputs_counter <= in_cnt_nxt;
                if (new_run)
                    o_gen_counter <= '0;
                else if (gen_take)
                    o_gen_counter <= gen_inc;
                if (nxt == S_STOP)
                    o_valid_lvl <= 1'b1;
            end

            // Population reuse stays selected from the first publication until the block idles.
            if (nxt == S_IDLE)
                self_algo_chrom_mux_sel <= 1'b0;
            else if ((nxt == S_STOP) || ((state == S_READY) && accept))
                self_algo_chrom_mux_sel <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ga_main_fsm_mc.sv
// Scoreboard bench for ga_main_fsm_mc: plays the GA datapath and checks sequencing and published weights.
`timescale 1ns/1ps
module tb_ga_main_fsm_mc;

    localparam int DATA_W  = 6;
    localparam int M_MAX   = 32;
    localparam int B_MAX   = 64;
    localparam int G_MAX   = 1024;
    localparam int B_MAX_W = $clog2(B_MAX + 1);
    localparam int G_MAX_W = $clog2(G_MAX + 1);
    localparam int CW      = DATA_W * M_MAX;

    logic               clk = 1'b0;
    logic               rst;
    logic [B_MAX_W-1:0] cnfg_b;
    logic [G_MAX_W-1:0] cnfg_g;
    logic [G_MAX_W-1:0] cnfg_stall;
    logic               i_ga_enable;
    logic               i_valid_pls;
    logic [CW-1:0]      i_v_vec_flat_n;
    logic               algo_self_gen_created_pls;
    logic [CW-1:0]      algo_self_best_chrom;
    logic               o_ga_ready;
    logic               o_valid_lvl;
    logic [CW-1:0]      o_w_vec_np1;
    logic [B_MAX_W-1:0] o_inputs_counter;
    logic [G_MAX_W-1:0] o_gen_counter;
    logic [7:0]         o_drop_cnt;
    logic               o_early_stop;
    logic               init_pls;
    logic               fit_en;
    logic               req_pls;
    logic               stop_pls;
    logic               mux_sel;

    int n_checks = 0;
    int n_fail   = 0;
    int init_cnt = 0;
    int req_cnt  = 0;
    int stop_cnt = 0;
    logic [CW-1:0] exp_w_q[$];

    always #5 clk = ~clk;

    ga_main_fsm_mc #(
        .DATA_W(DATA_W), .M_MAX(M_MAX), .B_MAX(B_MAX), .G_MAX(G_MAX)
    ) dut (
        .clk                                    (clk),
        .rst                                    (rst),
        .cnfg_b                                 (cnfg_b),
        .cnfg_g                                 (cnfg_g),
        .cnfg_stall                             (cnfg_stall),
        .i_ga_enable                            (i_ga_enable),
        .i_valid_pls                            (i_valid_pls),
        .i_v_vec_flat_n                         (i_v_vec_flat_n),
        .algo_self_gen_created_pls              (algo_self_gen_created_pls),
        .algo_self_best_chrom                   (algo_self_best_chrom),
        .o_ga_ready                             (o_ga_ready),
        .o_valid_lvl                            (o_valid_lvl),
        .o_w_vec_np1                            (o_w_vec_np1),
        .o_inputs_counter                       (o_inputs_counter),
        .o_gen_counter                          (o_gen_counter),
        .o_drop_cnt                             (o_drop_cnt),
        .o_early_stop                           (o_early_stop),
        .self_algo_init_pop_start               (init_pls),
        .self_algo_fit_enable                   (fit_en),
        .self_algo_create_new_gen_req_pls       (req_pls),
        .self_algo_stop_create_new_gens_req_pls (stop_pls),
        .self_algo_chrom_mux_sel                (mux_sel)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Pulse counting, one-cycle width, and publication scoreboard.
    logic prev_init = 1'b0;
    logic prev_req  = 1'b0;
    logic prev_stop = 1'b0;

    always @(posedge clk) begin
        #1;
        chk("pulse_width", {prev_init & init_pls, prev_req & req_pls, prev_stop & stop_pls}, 0);
        if (init_pls) init_cnt++;
        if (req_pls)  req_cnt++;
        if (stop_pls) stop_cnt++;
        if (stop_pls && o_valid_lvl) begin
            if (exp_w_q.size() == 0)
                chk("sb_underflow", 1, 0);
            else
                chk("w_vec_published", o_w_vec_np1, exp_w_q.pop_front());
        end
        prev_init = init_pls;
        prev_req  = req_pls;
        prev_stop = stop_pls;
    end

    task automatic zero_cnts();
        init_cnt = 0;
        req_cnt  = 0;
        stop_cnt = 0;
    endtask

    task automatic send_valid();
        i_valid_pls = 1'b1;
        @(negedge clk);
        i_valid_pls = 1'b0;
    endtask

    task automatic wait_req();
        bit seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (req_pls) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("req_seen", seen, 1);
    endtask

    task automatic do_gen(input logic [CW-1:0] best);
        wait_req();
        @(negedge clk);
        algo_self_gen_created_pls = 1'b1;
        algo_self_best_chrom      = best;
        @(negedge clk);
        algo_self_gen_created_pls = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_ga_enable = 1'b0; i_valid_pls = 1'b0;
        algo_self_gen_created_pls = 1'b0; algo_self_best_chrom = '0;
        i_v_vec_flat_n = CW'(32'h5a5a_1234);
        cnfg_b = 3; cnfg_g = 4; cnfg_stall = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {o_ga_ready, o_valid_lvl, o_inputs_counter, o_gen_counter, o_drop_cnt,
                         o_early_stop, init_pls, fit_en, req_pls, stop_pls, mux_sel}, 0);
        chk("rst_w", o_w_vec_np1, 0);

        // First run: 3 samples, 4 generations
        rst = 1'b0; i_ga_enable = 1'b1; zero_cnts();
        @(negedge clk);
        chk("collect_ready", o_ga_ready, 1);
        chk("mux_before_stop", mux_sel, 0);
        exp_w_q.push_back(CW'(111) + CW'(333));
        repeat (3) send_valid();
        chk("init_pulse", {init_pls, fit_en, o_ga_ready}, 3'b110);
        do_gen(CW'(111)); do_gen(CW'(222)); do_gen(CW'(333)); do_gen(CW'(444));
        chk("stop_valid_lvl", o_valid_lvl, 1);
        @(negedge clk);
        chk("r1_init_cnt", init_cnt, 1);
        chk("r1_req_cnt", req_cnt, 4);
        chk("r1_stop_cnt", stop_cnt, 1);
        chk("r1_w", o_w_vec_np1, 444);
        chk("r1_inputs", o_inputs_counter, 3);
        chk("r1_gen", o_gen_counter, 4);
        chk("r1_ready_mux", {o_ga_ready, mux_sel, o_early_stop}, 3'b110);

        // Second run from READY: reuse population, no init
        zero_cnts();
        exp_w_q.push_back(CW'(888));
        send_valid();
        chk("r2_mux", mux_sel, 1);
        do_gen(CW'(555)); do_gen(CW'(666)); do_gen(CW'(777)); do_gen(CW'(888));
        @(negedge clk);
        chk("r2_init_cnt", init_cnt, 0);
        chk("r2_req_cnt", req_cnt, 4);
        chk("r2_stop_cnt", stop_cnt, 1);
        chk("r2_w", o_w_vec_np1, 888);
        chk("r2_inputs", o_inputs_counter, 4);

        // Stray gen_created in READY, then drops during WAIT
        algo_self_gen_created_pls = 1'b1; algo_self_best_chrom = CW'(999);
        @(negedge clk);
        algo_self_gen_created_pls = 1'b0;
        chk("stray_gen_ignored", {o_ga_ready, o_gen_counter}, {1'b1, G_MAX_W'(4)});
        exp_w_q.push_back(CW'(12'hABC));
        send_valid();
        wait_req();
        @(negedge clk);
        chk("wait_not_ready", o_ga_ready, 0);
        i_valid_pls = 1'b1;
        @(negedge clk);
        i_valid_pls = 1'b0;
        chk("wait_drop1", {o_drop_cnt, o_inputs_counter, o_ga_ready}, {8'd1, B_MAX_W'(5), 1'b0});
        i_valid_pls = 1'b1; algo_self_gen_created_pls = 1'b1; algo_self_best_chrom = CW'(12'h101);
        @(negedge clk);
        i_valid_pls = 1'b0; algo_self_gen_created_pls = 1'b0;
        chk("wait_drop2_gen", {o_drop_cnt, o_gen_counter, o_inputs_counter},
            {8'd2, G_MAX_W'(1), B_MAX_W'(5)});
        do_gen(CW'(12'h202)); do_gen(CW'(12'h303)); do_gen(CW'(12'hABC));
        chk("r3_gen", o_gen_counter, 4);
        @(negedge clk);

        // Stall run: same best every generation
        cnfg_stall = 2; zero_cnts();
        exp_w_q.push_back(CW'(111));
        send_valid();
        do_gen(CW'(111)); do_gen(CW'(111)); do_gen(CW'(111));
`ifdef GA_EARLY_STOP_EN
        chk("es_gen", o_gen_counter, 3);
        chk("es_flag", {o_early_stop, o_valid_lvl}, 2'b11);
`else
        do_gen(CW'(111));
        chk("es_gen", o_gen_counter, 4);
        chk("es_flag", {o_early_stop, o_valid_lvl}, 2'b01);
`endif
        @(negedge clk);
        chk("es_stop_cnt", stop_cnt, 1);
        cnfg_stall = 0;

        // Enable dropped during WAIT
        zero_cnts();
        send_valid();
        wait_req();
        @(negedge clk);
        i_ga_enable = 1'b0;
        @(negedge clk);
        chk("en_drop_stop", stop_pls, 1);
        @(negedge clk);
        chk("en_drop_stop_cnt", stop_cnt, 1);
        chk("en_drop_w_held", o_w_vec_np1, 111);
        chk("en_drop_outs", {o_valid_lvl, o_inputs_counter, o_gen_counter, mux_sel, o_ga_ready, fit_en}, 0);
        chk("en_drop_drop_held", o_drop_cnt, 2);

        // Reset during WAIT after gen 2, then single-generation rerun
        i_ga_enable = 1'b1; cnfg_b = 1;
        @(negedge clk);
        send_valid();
        do_gen(CW'(1)); do_gen(CW'(2));
        wait_req();
        @(negedge clk);
        zero_cnts();
        rst = 1'b1;
        #1;
        chk("midrst_outs", {o_ga_ready, o_valid_lvl, o_inputs_counter, o_gen_counter, o_drop_cnt,
                            o_early_stop, init_pls, fit_en, req_pls, stop_pls, mux_sel}, 0);
        chk("midrst_w", o_w_vec_np1, 0);
        @(negedge clk);
        rst = 1'b0; cnfg_g = 0; cnfg_b = 0;
        @(negedge clk);
        chk("midrst_no_stop", stop_cnt, 0);
        chk("midrst_collect", o_ga_ready, 1);
        zero_cnts();
        exp_w_q.push_back(CW'(12'h777));
        send_valid();
        do_gen(CW'(12'h777));
        chk("g0_gen", {o_gen_counter, o_valid_lvl}, {G_MAX_W'(1), 1'b1});
        @(negedge clk);
        chk("g0_counts", {init_cnt[7:0], req_cnt[7:0], stop_cnt[7:0]}, {8'd1, 8'd1, 8'd1});
        chk("g0_inputs", o_inputs_counter, 1);

        chk("sb_empty", exp_w_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
